// File: rtl/memshare_l1pa_seq_mc.sv
// memshare_l1pa_seq_mc: multi-channel L1PA shift-sequence controller sharing one regfile.
// Each channel walks its mode slot of pages, emitting shift, last flag and the rotated address vector.
module memshare_l1pa_seq_mc #(
  parameter int SHARE_GROUP_SIZE = 5,
  parameter int GROUP_NUM = 2,
  parameter int RQST_ADDR_BITWIDTH = 4,
  parameter int RQST_MODE_BITWIDTH = 2,
  parameter int L1PA_REGFILE_PAGE_NUM = 8,
  parameter int SEQ_STRIDE = 4,
  localparam int SHIFT_W = $clog2(SHARE_GROUP_SIZE),
  localparam int PTR_W = $clog2(L1PA_REGFILE_PAGE_NUM),
  localparam int L1PA_REGFILE_PAGE_WIDTH = SHIFT_W + 1,
  localparam int VEC_W = SHARE_GROUP_SIZE * RQST_ADDR_BITWIDTH
) (
  input  logic                                   sys_clk,
  input  logic                                   rstn,
  input  logic [GROUP_NUM-1:0]                   rqst_valid_i,
  output logic [GROUP_NUM-1:0]                   rqst_ready_o,
  input  logic [GROUP_NUM*RQST_MODE_BITWIDTH-1:0] modeSet_i,
  input  logic [GROUP_NUM*VEC_W-1:0]             rqst_addr_i,
  output logic [GROUP_NUM-1:0]                   out_valid_o,
  input  logic [GROUP_NUM-1:0]                   out_ready_i,
  output logic [GROUP_NUM*SHIFT_W-1:0]           l1pa_shift_o,
  output logic [GROUP_NUM-1:0]                   isGtr_o,
  output logic [GROUP_NUM*VEC_W-1:0]             perm_addr_o,
  output logic [GROUP_NUM-1:0]                   modeErr_o,
  input  logic [PTR_W-1:0]                       regType0_waddr_i,
  input  logic [L1PA_REGFILE_PAGE_WIDTH-1:0]     regType0_wdata_i,
  input  logic                                   regType0_we_i
);
  localparam int MODE_NUM = L1PA_REGFILE_PAGE_NUM / SEQ_STRIDE;
  typedef enum logic {IDLE, RUN} stateT;
  logic [L1PA_REGFILE_PAGE_WIDTH-1:0] regFile [L1PA_REGFILE_PAGE_NUM];
  always_ff @(posedge sys_clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < L1PA_REGFILE_PAGE_NUM; i++) regFile[i] <= '0;
    end else if (regType0_we_i) begin
      regFile[regType0_waddr_i] <= regType0_wdata_i;
    end
  for (genvar g = 0; g < GROUP_NUM; g++) begin : gCh
    stateT state, stateNxt;
    logic [PTR_W-1:0] ptr, ptrNxt, base, baseNxt;
    logic [VEC_W-1:0] addrLat, addrLatNxt, perm;
    logic [RQST_MODE_BITWIDTH-1:0] mode;
    logic [L1PA_REGFILE_PAGE_WIDTH-1:0] page;
    logic [SHIFT_W-1:0] shift;
    logic run, modeOk, accept, isGtr, modeErr, modeErrNxt;
    int rot;
    assign mode = modeSet_i[g*RQST_MODE_BITWIDTH +: RQST_MODE_BITWIDTH];
    assign run = state == RUN;
    assign modeOk = int'(mode) < MODE_NUM;
    assign accept = !run && rqst_valid_i[g] && modeOk;
    assign page = regFile[ptr];
    // the slot boundary forces the end even when the page's last bit is clear
    assign isGtr = run && (page[SHIFT_W] || ptr == PTR_W'(int'(base) + SEQ_STRIDE - 1));
    assign shift = run ? page[SHIFT_W-1:0] : '0;
    assign rot = int'(shift) % SHARE_GROUP_SIZE;
    always_comb begin
      stateNxt = accept ? RUN : (run && out_ready_i[g] && isGtr) ? IDLE : state;
      baseNxt = accept ? PTR_W'(int'(mode) * SEQ_STRIDE) : base;
      ptrNxt = accept ? baseNxt : (run && out_ready_i[g] && !isGtr) ? ptr + 1'b1 : ptr;
      addrLatNxt = accept ? rqst_addr_i[g*VEC_W +: VEC_W] : addrLat;
      modeErrNxt = !run && rqst_valid_i[g] && !modeOk;
    end
    always_comb begin
      perm = '0;
      for (int j = 0; j < SHARE_GROUP_SIZE; j++)
        perm[j*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH] = run ?
          addrLat[((j + rot) % SHARE_GROUP_SIZE)*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH] : '0;
    end
    always_ff @(posedge sys_clk or negedge rstn)
      if (!rstn) begin
        state <= IDLE;
        ptr <= '0;
        base <= '0;
        addrLat <= '0;
        modeErr <= 1'b0;
      end else begin
        state <= stateNxt;
        ptr <= ptrNxt;
        base <= baseNxt;
        addrLat <= addrLatNxt;
        modeErr <= modeErrNxt;
      end
    assign rqst_ready_o[g] = !run;
    assign out_valid_o[g] = run;
    assign isGtr_o[g] = isGtr;
    assign modeErr_o[g] = modeErr;
    assign l1pa_shift_o[g*SHIFT_W +: SHIFT_W] = shift;
    assign perm_addr_o[g*VEC_W +: VEC_W] = perm;
  end
endmodule

// File: tb/tb_memshare_l1pa_seq_mc.sv
// tb_memshare_l1pa_seq_mc: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_memshare_l1pa_seq_mc;
  localparam int SZ = 5, GN = 2, AW = 4, MW = 2, PN = 8, ST = 4, SW = 3, PW = 4, PTRW = 3, VW = SZ * AW;
  logic sys_clk = 1'b0, rstn = 1'b0;
  logic [GN-1:0] rqst_valid_i = '0, out_ready_i = '0, rqst_ready_o, out_valid_o, isGtr_o, modeErr_o;
  logic [GN*MW-1:0] modeSet_i = '0;
  logic [GN*VW-1:0] rqst_addr_i = '0, perm_addr_o;
  logic [GN*SW-1:0] l1pa_shift_o;
  logic [PTRW-1:0] regType0_waddr_i = '0;
  logic [PW-1:0] regType0_wdata_i = '0;
  logic regType0_we_i = 1'b0;
  typedef struct packed {logic [SW-1:0] shift; logic gtr; logic [VW-1:0] perm;} beatT;
  beatT expQ[GN][$];
  logic [PW-1:0] pages[PN];
  logic [PW-1:0] preload[PN] = '{4'h1, 4'h2, 4'h3, 4'hC, 4'h0, 4'h4, 4'h2, 4'h1};
  int nChk = 0, nFail = 0;
  int errExp[GN] = '{0, 0}, errSeen[GN] = '{0, 0};
  logic [GN-1:0] bubble = '0;

  always #5 sys_clk = ~sys_clk;

  memshare_l1pa_seq_mc dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .rqst_valid_i(rqst_valid_i), .rqst_ready_o(rqst_ready_o),
    .modeSet_i(modeSet_i), .rqst_addr_i(rqst_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .l1pa_shift_o(l1pa_shift_o), .isGtr_o(isGtr_o), .perm_addr_o(perm_addr_o),
    .modeErr_o(modeErr_o),
    .regType0_waddr_i(regType0_waddr_i), .regType0_wdata_i(regType0_wdata_i),
    .regType0_we_i(regType0_we_i)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // element j of the result is element (j+s) mod SZ of the request vector
  function automatic logic [VW-1:0] rotate(logic [VW-1:0] a, int s);
    int el[SZ];
    logic [VW-1:0] r;
    for (int j = 0; j < SZ; j++) el[j] = int'(a[j*AW +: AW]);
    r = '0;
    for (int j = 0; j < SZ; j++) r[j*AW +: AW] = AW'(el[(j + s) % SZ]);
    return r;
  endfunction

  function automatic void pushSeq(int c, int mode, logic [VW-1:0] a);
    beatT b;
    if (mode >= PN / ST) begin
      errExp[c]++;
      return;
    end
    for (int k = 0; k < ST; k++) begin
      b.shift = pages[mode*ST + k][SW-1:0];
      b.gtr = pages[mode*ST + k][SW] || k == ST - 1;
      b.perm = rotate(a, int'(b.shift) % SZ);
      expQ[c].push_back(b);
      if (b.gtr) break;
    end
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic req(int c, int mode, logic [VW-1:0] a);
    rqst_valid_i[c] = 1'b1;
    modeSet_i[c*MW +: MW] = MW'(mode);
    rqst_addr_i[c*VW +: VW] = a;
    pushSeq(c, mode, a);
  endtask

  task automatic wr(int p, logic [PW-1:0] d);
    regType0_we_i = 1'b1;
    regType0_waddr_i = PTRW'(p);
    regType0_wdata_i = d;
    pages[p] = d;
    tick();
    regType0_we_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ[0].size() != 0 || expQ[1].size() != 0 || rqst_ready_o != '1) && n < 200) begin
      tick();
      n++;
    end
    check("drain_pending_beats", expQ[0].size() + expQ[1].size(), 0);
    tick();
  endtask

  initial begin : monitor
    beatT b;
    logic [SW-1:0] sh;
    logic [VW-1:0] pm;
    forever begin
      @(negedge sys_clk);
      if (!rstn) bubble = '0;
      else begin
        for (int c = 0; c < GN; c++) begin
          sh = l1pa_shift_o[c*SW +: SW];
          pm = perm_addr_o[c*VW +: VW];
          if (bubble[c]) check($sformatf("bubble_ready_ch%0d", c), {rqst_ready_o[c], out_valid_o[c]}, 2'b10);
          bubble[c] = 1'b0;
          if (modeErr_o[c]) errSeen[c]++;
          if (!out_valid_o[c]) check($sformatf("idle_zero_ch%0d", c), {isGtr_o[c], sh, pm}, 0);
          else if (out_ready_i[c]) begin
            if (expQ[c].size() == 0) begin
              nChk++;
              nFail++;
              $display("FAIL beat_ch%0d: got unexpected beat shift %0d, required none", c, sh);
            end else begin
              b = expQ[c].pop_front();
              check($sformatf("beat_ch%0d", c), {sh, isGtr_o[c], pm}, b);
              bubble[c] = b.gtr;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [VW-1:0] a;
    for (int p = 0; p < PN; p++) pages[p] = '0;
    tick();
    rstn = 1'b1;
    tick();
    req(0, 0, VW'(20'h12345));
    tick();
    rqst_valid_i = '0;
    check("midrun_valid", out_valid_o[0], 1);
    #2 rstn = 1'b0;
    #1;
    check("rst_ready", rqst_ready_o, 2'b11);
    check("rst_outputs", {out_valid_o, isGtr_o, modeErr_o, l1pa_shift_o}, 0);
    check("rst_perm", perm_addr_o, 0);
    expQ[0].delete();
    expQ[1].delete();
    tick();
    tick();
    rstn = 1'b1;
    out_ready_i = '1;
    for (int p = 0; p < PN; p++) wr(p, preload[p]);
    a = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    req(0, 0, a);
    tick();
    rqst_valid_i = '0;
    check("first_beat_latency", out_valid_o[0], 1);
    check("first_perm", perm_addr_o[VW-1:0], {4'd0, 4'd4, 4'd3, 4'd2, 4'd1});
    drain();
    req(0, 1, VW'($urandom));
    tick();
    rqst_valid_i = '0;
    drain();
    pages[5] = 4'h3;
    req(1, 1, VW'($urandom));
    tick();
    rqst_valid_i = '0;
    tick();
    out_ready_i[1] = 1'b0;
    check("stall_shift_before_write", l1pa_shift_o[SW +: SW], 4);
    regType0_we_i = 1'b1;
    regType0_waddr_i = 3'd5;
    regType0_wdata_i = 4'h3;
    tick();
    regType0_we_i = 1'b0;
    check("stall_shift_after_write", l1pa_shift_o[SW +: SW], 3);
    tick();
    check("stall_hold", {out_valid_o[1], l1pa_shift_o[SW +: SW]}, {1'b1, 3'd3});
    tick();
    out_ready_i[1] = 1'b1;
    drain();
    a = VW'($urandom);
    req(0, 0, a);
    req(1, 0, a);
    tick();
    rqst_valid_i = '0;
    drain();
    req(0, 2, VW'($urandom));
    tick();
    rqst_valid_i = '0;
    check("mode_err_pulse", {modeErr_o[0], out_valid_o[0], rqst_ready_o[0]}, 3'b101);
    tick();
    check("mode_err_one_cycle", {modeErr_o[0], out_valid_o[0]}, 2'b00);
    wr(0, 4'h6);
    a = VW'($urandom);
    req(0, 0, a);
    tick();
    rqst_valid_i = '0;
    check("ovf_shift", l1pa_shift_o[SW-1:0], 6);
    check("ovf_perm", perm_addr_o[VW-1:0], rotate(a, 1));
    drain();
    for (int p = 0; p < PN; p++) wr(p, PW'($urandom));
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < GN; c++)
        if (rqst_ready_o[c] && $urandom_range(2) == 0) req(c, $urandom_range(3), VW'($urandom));
        else rqst_valid_i[c] = 1'b0;
      out_ready_i = GN'($urandom);
      tick();
    end
    rqst_valid_i = '0;
    out_ready_i = '1;
    drain();
    for (int c = 0; c < GN; c++) check($sformatf("mode_err_count_ch%0d", c), errSeen[c], errExp[c]);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule

// File: doc/memshare_l1pa_seq_mc.md
# memshare_l1pa_seq_mc

Multi-channel L1PA shift-sequence controller, the parametrised successor of the single-group memShare control wrapper. It serves GROUP_NUM independent share groups from one shared L1PA register file. Each group accepts an address request, then walks a mode-selected shift sequence. Each beat carries the L1PA shift, the last-pattern flag (isGtr) and the request-address vector rotated by that shift. It sits between the access-request generator and the L1PA permutation network.

## Interface
- SHARE_GROUP_SIZE, 5: requestors per share group; SHIFT_W = $clog2(SHARE_GROUP_SIZE).
- GROUP_NUM, 2: number of independent channels (share groups).
- RQST_ADDR_BITWIDTH, 4: width of one requestor address.
- RQST_MODE_BITWIDTH, 2: mode field width per channel.
- L1PA_REGFILE_PAGE_NUM, 8: regfile depth; PTR_W = $clog2(L1PA_REGFILE_PAGE_NUM).
- SEQ_STRIDE, 4: pages per mode slot. Must divide L1PA_REGFILE_PAGE_NUM. MODE_NUM = L1PA_REGFILE_PAGE_NUM/SEQ_STRIDE.
- Page layout: L1PA_REGFILE_PAGE_WIDTH = SHIFT_W+1. Bits [SHIFT_W-1:0] hold the shift; bit [SHIFT_W] is the last flag.
- Channel c occupies slice c of every packed per-channel port.

Ports:
- sys_clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- rqst_valid_i  in  GROUP_NUM  request valid per channel.
- rqst_ready_o  out  GROUP_NUM  channel idle, can accept.
- modeSet_i  in  GROUP_NUM*RQST_MODE_BITWIDTH  sequence mode per channel.
- rqst_addr_i  in  GROUP_NUM*SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH  address vectors.
- out_valid_o  out  GROUP_NUM  beat valid.
- out_ready_i  in  GROUP_NUM  downstream accepts beat.
- l1pa_shift_o  out  GROUP_NUM*SHIFT_W  raw shift of current page.
- isGtr_o  out  GROUP_NUM  current beat is last of sequence.
- perm_addr_o  out  GROUP_NUM*SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH  rotated address vector.
- modeErr_o  out  GROUP_NUM  one-cycle pulse: request rejected for bad mode.
- regType0_waddr_i  in  PTR_W  regfile write address.
- regType0_wdata_i  in  L1PA_REGFILE_PAGE_WIDTH  regfile write data.
- regType0_we_i  in  1  regfile write enable.

## Operation
- Regfile: flop array, one write port, one combinational read per channel. The write lands at the rising edge. A same-cycle read returns the old contents.
- Per-channel FSM with two states, IDLE and RUN.
- IDLE:
  - rqst_ready_o=1.
  - On rqst_valid_i with mode < MODE_NUM: latch the address vector, set ptr = mode*SEQ_STRIDE (PTR_W arithmetic), and go to RUN.
  - On rqst_valid_i with mode >= MODE_NUM: modeErr_o=1 for the next cycle and stay in IDLE. The request is consumed.
- RUN:
  - out_valid_o=1, rqst_ready_o=0.
  - l1pa_shift_o = page[ptr].shift.
  - isGtr_o = page[ptr].last OR (ptr == base+SEQ_STRIDE-1). A sequence never crosses its mode slot.
  - On out_ready_i with isGtr_o: go to IDLE. Otherwise on out_ready_i: ptr+1.
  - With out_ready_i low, all outputs hold, except that l1pa_shift_o/isGtr_o track regfile writes to page[ptr].
- perm_addr_o element j = latched element ((j + s) mod SHARE_GROUP_SIZE), where s = shift mod SHARE_GROUP_SIZE. Shift values ≥ SHARE_GROUP_SIZE appear raw on l1pa_shift_o.
- Channels are fully independent and may read the same page simultaneously.

## Timing
- Reset (async, any time):
  - FSMs go to IDLE and ptrs to 0.
  - The regfile clears to 0.
  - rqst_ready_o=all 1; out_valid_o, isGtr_o, modeErr_o, l1pa_shift_o and perm_addr_o all 0.
  - Reset mid-sequence abandons the sequence with no last beat.
- Request accepted at edge T: the first beat is valid in cycle T+1.
- Each beat lasts ≥1 cycle; throughput is 1 beat/cycle with out_ready_i held high.
- After the last beat is accepted at edge E, rqst_ready_o=1 in cycle E+1. There is no same-cycle re-accept, so there is a one-cycle bubble between sequences.
- In IDLE, perm_addr_o/l1pa_shift_o/isGtr_o hold 0.
- modeErr_o is high exactly one cycle, after the rejecting edge.

## Test plan
- Reset/preload:
  - Stimulus: assert rstn low mid-RUN, then write pages 0..7 with {last,shift} = 0x1,0x2,0x3,0xC,0x0,0x4,0x2,0x1.
  - Required: all outputs 0 immediately on reset. Readback through sequences matches the written pages.
- Mode 0, ch0, out_ready_i=1:
  - Stimulus: address vector {4,3,2,1,0} (element 0 = 0).
  - Required: beats shift 1,2,3,4 with isGtr only on the 4th beat (page 3 last). First beat perm_addr = {0,4,3,2,1}. Ready returns the cycle after beat 4.
- Mode 1, forced end:
  - Stimulus: page 7 last bit = 0.
  - Required: beats shift 0,4,2,1. isGtr is set on the 4th beat from the slot boundary. Shift 4 rotates by 4.
- Backpressure on ch1, mode 1:
  - Stimulus: hold out_ready_i=0 for 3 cycles on beat 2, while writing page 5 = 0x3 during the stall.
  - Required: ptr holds. l1pa_shift_o changes 4→3 one cycle after the write edge.
- Concurrency and error:
  - Stimulus: ch0 and ch1 both request mode 0 in the same cycle. Separately, a request with mode 2 (MODE_NUM = 2).
  - Required: identical beat streams on both channels. The mode-2 request gives a 1-cycle modeErr_o, no out_valid_o, and rqst_ready_o stays 1.
- Shift overflow:
  - Stimulus: page shift = 6 (SHIFT_W = 3).
  - Required: l1pa_shift_o = 6, perm_addr rotated by 1.
